pipeline_redirect_controller: RTL and testbench

//  Sequences PC redirection and pipeline flush/stall for the 5-stage RV32IM core. Consumes the EX-stage

---
 rtl/pipeline_ctrl_pkg.sv | 18 +
 rtl/hazard_detect_unit.sv | 27 ++
 rtl/pipeline_redirect_controller.sv | 188 ++++++++++++++++++
 tb/tb_pipeline_redirect_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline redirect controller: FSM state codes,
// default datapath widths and the NOP encoding used by the pipeline registers.
package pipeline_ctrl_pkg;

  localparam int DEF_XLEN       = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_STAT_W     = 32;

  typedef logic [1:0] state_t;

  localparam state_t S_RUN      = 2'd0;
  localparam state_t S_REDIRECT = 2'd1;
  localparam state_t S_MEMWAIT  = 2'd2;

  // ADDI x0, x0, 0 -- what a flushed pipeline register holds
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_detect_unit.sv
// Combinational load-use compare: flags when the ID instruction reads the
// register that a load currently in EX will write.
module hazard_detect_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  output logic                  hazard
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 never carries a real dependency, so a load into x0 cannot cause a stall
  always_comb begin
    rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    hazard  = ex_mem_read && (ex_rd != {REG_ADDR_W{1'b0}}) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_redirect_controller.sv
// PC redirect / flush / stall sequencer for the 5-stage core.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module pipeline_redirect_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int STAT_W     = DEF_STAT_W
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  branch_valid,
  input  logic                  branch_taken,
  input  logic [XLEN-1:0]       branch_target,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  mem_busy,
  output logic                  pc_sel,
  output logic [XLEN-1:0]       pc_target,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  stall_pipe,
  output logic                  target_misaligned,
  output logic [STAT_W-1:0]     stat_branches,
  output logic [STAT_W-1:0]     stat_taken,
  output logic [STAT_W-1:0]     stat_stalls
);

  state_t          state;
  state_t          next_state;
  logic            pending;
  logic            next_pending;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] next_target;
  logic            hazard;
  logic            load_use;

  hazard_detect_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .hazard      (hazard)
  );

  // State register with synchronous reset; reset also drops any pending redirect
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_RUN;
      pending  <= 1'b0;
      target_q <= {XLEN{1'b0}};
    end else begin
      state    <= next_state;
      pending  <= next_pending;
      target_q <= next_target;
    end
  end

  // Next-state logic: a stall outranks a redirect, and a redirect resolved
  // under a stall is parked in pending until memory becomes ready
  always_comb begin
    next_state   = state;
    next_pending = pending;
    next_target  = target_q;
    case (state)
      S_RUN: begin
        if (mem_busy) begin
          next_state   = S_MEMWAIT;
          next_pending = branch_valid && branch_taken;
          next_target  = branch_target;
        end else if (branch_valid && branch_taken) begin
          next_state  = S_REDIRECT;
          next_target = branch_target;
        end else begin
          next_state = S_RUN;
        end
      end
      S_REDIRECT: begin
        if (mem_busy) begin
          next_state   = S_MEMWAIT;
          next_pending = 1'b0;
        end else begin
          next_state = S_RUN;
        end
      end
      S_MEMWAIT: begin
        if (!mem_busy) begin
          next_state   = pending ? S_REDIRECT : S_RUN;
          next_pending = 1'b0;
        end else begin
          next_state = S_MEMWAIT;
        end
      end
      default: begin
        next_state   = S_RUN;
        next_pending = 1'b0;
      end
    endcase
  end

  // Outputs: redirect/flush/freeze follow the state; load-use reacts in the same cycle
  always_comb begin
    pc_sel            = 1'b0;
    pc_target         = {XLEN{1'b0}};
    flush_if_id       = 1'b0;
    flush_id_ex       = 1'b0;
    stall_if          = 1'b0;
    stall_id          = 1'b0;
    bubble_ex         = 1'b0;
    stall_pipe        = 1'b0;
    target_misaligned = 1'b0;
    load_use          = 1'b0;
    case (state)
      S_RUN: begin
        load_use  = hazard && !mem_busy && !branch_valid;
        stall_if  = load_use;
        stall_id  = load_use;
        bubble_ex = load_use;
      end
      S_REDIRECT: begin
        pc_sel            = 1'b1;
        pc_target         = {target_q[XLEN-1:1], 1'b0};
        flush_if_id       = 1'b1;
        flush_id_ex       = 1'b1;
        target_misaligned = target_q[1];
      end
      S_MEMWAIT: begin
        stall_pipe = 1'b1;
        stall_if   = 1'b1;
        stall_id   = 1'b1;
      end
      default: begin
        stall_pipe = 1'b0;
      end
    endcase
  end

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] cnt_branches;
  logic [STAT_W-1:0] cnt_taken;
  logic [STAT_W-1:0] cnt_stalls;

  // Event counters, wrapping naturally at 2^STAT_W
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_branches <= {STAT_W{1'b0}};
      cnt_taken    <= {STAT_W{1'b0}};
      cnt_stalls   <= {STAT_W{1'b0}};
    end else begin
      if ((state == S_RUN) && branch_valid) begin
        cnt_branches <= cnt_branches + STAT_W'(1);
      end else begin
        cnt_branches <= cnt_branches;
      end
      if ((next_state == S_REDIRECT) && (state != S_REDIRECT)) begin
        cnt_taken <= cnt_taken + STAT_W'(1);
      end else begin
        cnt_taken <= cnt_taken;
      end
      if (load_use || (state == S_MEMWAIT)) begin
        cnt_stalls <= cnt_stalls + STAT_W'(1);
      end else begin
        cnt_stalls <= cnt_stalls;
      end
    end
  end

  assign stat_branches = cnt_branches;
  assign stat_taken    = cnt_taken;
  assign stat_stalls   = cnt_stalls;
`else
  assign stat_branches = {STAT_W{1'b0}};
  assign stat_taken    = {STAT_W{1'b0}};
  assign stat_stalls   = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_redirect_controller.sv
// Self-checking bench for pipeline_redirect_controller: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the redirect rules.
module tb_pipeline_redirect_controller;

  logic        CLK;
  logic        RESET;
  logic        branch_valid;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        mem_busy;
  logic        pc_sel;
  logic [31:0] pc_target;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        stall_if;
  logic        stall_id;
  logic        bubble_ex;
  logic        stall_pipe;
  logic        target_misaligned;
  logic [31:0] stat_branches;
  logic [31:0] stat_taken;
  logic [31:0] stat_stalls;

  int compared   = 0;
  int mismatched = 0;

  // Model: "redirect happens this cycle", "pipe frozen this cycle",
  // "a redirect is waiting for memory", and the captured target address.
  bit          m_redirect;
  bit          m_wait;
  bit          m_pend;
  logic [31:0] m_tgt;
  int unsigned m_branches;
  int unsigned m_taken;
  int unsigned m_stalls;

  pipeline_redirect_controller dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .branch_valid      (branch_valid),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .ex_mem_read       (ex_mem_read),
    .ex_rd             (ex_rd),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .id_use_rs1        (id_use_rs1),
    .id_use_rs2        (id_use_rs2),
    .mem_busy          (mem_busy),
    .pc_sel            (pc_sel),
    .pc_target         (pc_target),
    .flush_if_id       (flush_if_id),
    .flush_id_ex       (flush_id_ex),
    .stall_if          (stall_if),
    .stall_id          (stall_id),
    .bubble_ex         (bubble_ex),
    .stall_pipe        (stall_pipe),
    .target_misaligned (target_misaligned),
    .stat_branches     (stat_branches),
    .stat_taken        (stat_taken),
    .stat_stalls       (stat_stalls)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic bit ref_load_use();
    bit dep;
    dep = (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
    return !m_redirect && !m_wait && !mem_busy && !branch_valid &&
           ex_mem_read && (ex_rd != 5'd0) && dep;
  endfunction

  task automatic check_outputs();
    bit lu;
    lu = ref_load_use();
    check("pc_sel",      {31'd0, pc_sel},      {31'd0, m_redirect});
    check("flush_if_id", {31'd0, flush_if_id}, {31'd0, m_redirect});
    check("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, m_redirect});
    check("misaligned",  {31'd0, target_misaligned}, {31'd0, m_redirect && m_tgt[1]});
    if (m_redirect) check("pc_target", pc_target, m_tgt & 32'hFFFF_FFFE);
    check("stall_pipe",  {31'd0, stall_pipe}, {31'd0, m_wait});
    check("stall_if",    {31'd0, stall_if},   {31'd0, m_wait || lu});
    check("stall_id",    {31'd0, stall_id},   {31'd0, m_wait || lu});
    check("bubble_ex",   {31'd0, bubble_ex},  {31'd0, lu});
    check("stat_branches", stat_branches, m_branches);
    check("stat_taken",    stat_taken,    m_taken);
    check("stat_stalls",   stat_stalls,   m_stalls);
  endtask

  task automatic model_update();
    bit lu;
    bit was_redirect;
    lu = ref_load_use();
    was_redirect = m_redirect;
    if (RESET) begin
      m_redirect = 1'b0; m_wait = 1'b0; m_pend = 1'b0; m_tgt = 32'd0;
      m_branches = 0; m_taken = 0; m_stalls = 0;
    end else begin
`ifdef BRANCH_STATS_EN
      if (!m_redirect && !m_wait && branch_valid) m_branches++;
      if (lu || m_wait) m_stalls++;
`endif
      if (m_wait) begin
        if (!mem_busy) begin
          m_wait = 1'b0;
          m_redirect = m_pend;
          m_pend = 1'b0;
        end
      end else if (m_redirect) begin
        m_redirect = 1'b0;
        if (mem_busy) begin
          m_wait = 1'b1;
          m_pend = 1'b0;
        end
      end else if (mem_busy) begin
        m_wait = 1'b1;
        m_pend = branch_valid && branch_taken;
        m_tgt  = branch_target;
      end else if (branch_valid && branch_taken) begin
        m_redirect = 1'b1;
        m_tgt = branch_target;
      end
`ifdef BRANCH_STATS_EN
      if (m_redirect && !was_redirect) m_taken++;
`endif
    end
  endtask

  // Check outputs mid-cycle, then advance the model on the edge the DUT samples.
  task automatic cycle();
    @(negedge CLK);
    check_outputs();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    branch_valid = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    ex_mem_read = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic branch(input bit taken, input logic [31:0] tgt);
    branch_valid = 1'b1; branch_taken = taken; branch_target = tgt;
  endtask

  initial begin
    idle_inputs();
    RESET = 1'b1;
    @(posedge CLK);
    model_update();
    #1;
    cycle();
    RESET = 1'b0;
    cycle();

    // BEQ taken to 0x40, then one redirect cycle, then quiet
    branch(1'b1, 32'h0000_0040); cycle();
    idle_inputs(); cycle(); cycle();

    // BNE not taken
    branch(1'b0, 32'h0000_0080); cycle();
    idle_inputs(); cycle();

    // LW x5 in EX, ID reads x5 via rs2; then the same with ex_rd = x0
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1; id_rs1 = 5'd1;
    cycle();
    ex_rd = 5'd0; id_rs2 = 5'd0; cycle();
    idle_inputs(); cycle();

    // Taken jump to 0x100 while memory is busy for three cycles
    branch(1'b1, 32'h0000_0100); mem_busy = 1'b1; cycle();
    idle_inputs(); mem_busy = 1'b1; cycle(); cycle();
    mem_busy = 1'b0; cycle(); cycle(); cycle();

    // JALR to 0x103: aligned to 0x102 and flagged misaligned
    branch(1'b1, 32'h0000_0103); cycle();
    idle_inputs(); cycle(); cycle();

    // Reset while waiting on memory with a redirect parked
    branch(1'b1, 32'h0000_0200); mem_busy = 1'b1; cycle();
    idle_inputs(); mem_busy = 1'b1; cycle();
    RESET = 1'b1; cycle();
    RESET = 1'b0; mem_busy = 1'b0; cycle(); cycle(); cycle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      RESET         = ($urandom_range(0, 59) == 0);
      branch_valid  = ($urandom_range(0, 3) == 0);
      branch_taken  = $urandom_range(0, 1) == 1;
      branch_target = $urandom;
      ex_mem_read   = $urandom_range(0, 1) == 1;
      ex_rd         = 5'($urandom_range(0, 3));
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      id_use_rs1    = $urandom_range(0, 1) == 1;
      id_use_rs2    = $urandom_range(0, 1) == 1;
      mem_busy      = ($urandom_range(0, 5) == 0);
      cycle();
    end
    RESET = 1'b0;
    idle_inputs();
    cycle(); cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
